// File: rtl/ide_device.sv
`timescale 1ns/1ps
// ATA PIO device model: task-file registers, one-sector READ/WRITE against a block store.
// Define IDE_DEVICE_IDENTIFY_EN to accept IDENTIFY DEVICE (0xEC).
module ide_device #(
  parameter logic [23:0] SECTORS    = 24'd65536,
  parameter int          BSY_CYCLES = 8
) (
  input  logic        clk,
  input  logic        reset,
  inout  wire  [15:0] ide_data_bus,
  input  logic        ide_dior,
  input  logic        ide_diow,
  input  logic [1:0]  ide_cs,
  input  logic [2:0]  ide_da,
  output logic        ide_intrq,
  output logic [23:0] blk_lba,
  output logic [7:0]  blk_addr,
  output logic        blk_rd,
  output logic        blk_wr,
  output logic [15:0] blk_wdata,
  input  logic [15:0] blk_rdata
);

  localparam int            CW       = $clog2(BSY_CYCLES + 1);
  localparam logic [CW-1:0] BSY_LAST = CW'(BSY_CYCLES - 1);

  typedef enum logic [3:0] {IDLE, CMDWAIT, ABORT, FILL, IDENT, DRQ_OUT, DRQ_IN, FLUSH, RESETTING} state_t;
  state_t state;

  logic [1:0]    dior_s, diow_s;
  logic          dior_q, diow_q;
  logic [15:0]   wr_hold;
  logic [7:0]    error, seccnt, secnum, cyllow, cylhigh, drvhead, devctrl, cmd;
  logic          bsy, drq, err, fill_vld;
  logic [7:0]    ptr;
  logic [CW-1:0] cnt;
  logic [15:0]   buffer [256];
  logic [15:0]   rd_mux, buf_wd;
  logic          buf_we;

  wire        rd_commit = dior_s[1] & ~dior_q;
  wire        wr_commit = diow_s[1] & ~diow_q;
  wire        sel_cmd   = (ide_cs == 2'b10);
  wire        sel_ctl   = (ide_cs == 2'b01);
  wire [23:0] lba       = {cylhigh, cyllow, secnum};
  wire        nien      = devctrl[1];
  wire [7:0]  status    = {bsy, 1'b1, 1'b0, 1'b1, drq, 2'b00, err};
  wire        data_wr   = wr_commit && sel_cmd && (ide_da == 3'd0) && (state == DRQ_IN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dior_s <= 2'b11;
      diow_s <= 2'b11;
      dior_q <= 1'b1;
      diow_q <= 1'b1;
    end else begin
      dior_s <= {dior_s[0], ide_dior};
      diow_s <= {diow_s[0], ide_diow};
      dior_q <= dior_s[1];
      diow_q <= diow_s[1];
    end
  end

  always_comb begin
    rd_mux = '0;
    if (sel_cmd) begin
      case (ide_da)
        3'd0: rd_mux = (state == DRQ_OUT) ? buffer[ptr] : 16'h0000;
        3'd1: rd_mux = {8'h00, error};
        3'd2: rd_mux = {8'h00, seccnt};
        3'd3: rd_mux = {8'h00, secnum};
        3'd4: rd_mux = {8'h00, cyllow};
        3'd5: rd_mux = {8'h00, cylhigh};
        3'd6: rd_mux = {8'h00, drvhead};
        3'd7: rd_mux = {8'h00, status};
      endcase
    end else if (sel_ctl && ide_da == 3'd6) begin
      rd_mux = {8'h00, status};
    end
  end

  assign ide_data_bus = (!ide_dior && (sel_cmd || sel_ctl)) ? rd_mux : 16'hzzzz;

`ifdef IDE_DEVICE_IDENTIFY_EN
  logic [15:0] id_word;
  always_comb begin
    case (ptr)
      8'd49:   id_word = 16'h0200;
      8'd60:   id_word = SECTORS[15:0];
      8'd61:   id_word = {8'h00, SECTORS[23:16]};
      default: id_word = 16'h0000;
    endcase
  end
`endif

  // FILL, IDENTIFY and host DATA writes all load the sector buffer at ptr
  always_comb begin
    buf_we = 1'b0;
    buf_wd = blk_rdata;
    if (state == FILL && fill_vld) buf_we = 1'b1;
    if (data_wr) begin
      buf_we = 1'b1;
      buf_wd = wr_hold;
    end
`ifdef IDE_DEVICE_IDENTIFY_EN
    if (state == IDENT) begin
      buf_we = 1'b1;
      buf_wd = id_word;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (buf_we) buffer[ptr] <= buf_wd;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      wr_hold   <= '0;
      error     <= 8'h01;
      seccnt    <= 8'h01;
      secnum    <= '0;
      cyllow    <= '0;
      cylhigh   <= '0;
      drvhead   <= '0;
      devctrl   <= '0;
      cmd       <= '0;
      bsy       <= 1'b0;
      drq       <= 1'b0;
      err       <= 1'b0;
      fill_vld  <= 1'b0;
      ptr       <= '0;
      cnt       <= '0;
      ide_intrq <= 1'b0;
      blk_lba   <= '0;
      blk_addr  <= '0;
      blk_rd    <= 1'b0;
      blk_wr    <= 1'b0;
      blk_wdata <= '0;
    end else begin
      if (!diow_s[1]) wr_hold <= ide_data_bus;
      fill_vld <= 1'b0;

      case (state)
        CMDWAIT: begin
          if (cnt == BSY_LAST) begin
            cnt     <= '0;
            blk_lba <= lba;
            ptr     <= '0;
            if ((cmd == 8'h20 || cmd == 8'h30) && lba >= SECTORS) begin
              state <= ABORT;
            end else if (cmd == 8'h20) begin
              state    <= FILL;
              blk_rd   <= 1'b1;
              blk_addr <= '0;
            end else if (cmd == 8'h30) begin
              state <= DRQ_IN;
              bsy   <= 1'b0;
              drq   <= 1'b1;
`ifdef IDE_DEVICE_IDENTIFY_EN
            end else if (cmd == 8'hEC) begin
              state <= IDENT;
`endif
            end else begin
              state <= ABORT;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ABORT: begin
          error     <= 8'h04;
          err       <= 1'b1;
          bsy       <= 1'b0;
          ide_intrq <= ~nien;
          state     <= IDLE;
        end
        FILL: begin
          fill_vld <= blk_rd;
          if (blk_rd) begin
            if (blk_addr == 8'hFF) blk_rd <= 1'b0;
            else                   blk_addr <= blk_addr + 8'd1;
          end
          // returning word lands one clock after its strobe
          if (fill_vld) begin
            if (ptr == 8'hFF) begin
              ptr       <= '0;
              bsy       <= 1'b0;
              drq       <= 1'b1;
              ide_intrq <= ~nien;
              state     <= DRQ_OUT;
            end else begin
              ptr <= ptr + 8'd1;
            end
          end
        end
        IDENT: begin
          if (ptr == 8'hFF) begin
            ptr       <= '0;
            bsy       <= 1'b0;
            drq       <= 1'b1;
            ide_intrq <= ~nien;
            state     <= DRQ_OUT;
          end else begin
            ptr <= ptr + 8'd1;
          end
        end
        FLUSH: begin
          if (blk_addr == 8'hFF) begin
            blk_wr    <= 1'b0;
            bsy       <= 1'b0;
            ide_intrq <= ~nien;
            state     <= IDLE;
          end else begin
            blk_addr  <= blk_addr + 8'd1;
            blk_wdata <= buffer[blk_addr + 8'd1];
          end
        end
        RESETTING: begin
          if (!devctrl[2]) begin
            if (cnt == BSY_LAST) begin
              cnt   <= '0;
              bsy   <= 1'b0;
              err   <= 1'b0;
              error <= 8'h01;
              state <= IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase

      if (rd_commit && sel_cmd) begin
        if (ide_da == 3'd7) ide_intrq <= 1'b0;
        if (ide_da == 3'd0 && state == DRQ_OUT) begin
          if (ptr == 8'hFF) begin
            ptr   <= '0;
            drq   <= 1'b0;
            state <= IDLE;
          end else begin
            ptr <= ptr + 8'd1;
          end
        end
      end

      if (wr_commit && sel_cmd) begin
        case (ide_da)
          3'd0: begin
            if (data_wr) begin
              if (ptr == 8'hFF) begin
                ptr       <= '0;
                drq       <= 1'b0;
                bsy       <= 1'b1;
                state     <= FLUSH;
                blk_wr    <= 1'b1;
                blk_addr  <= '0;
                blk_wdata <= buffer[8'd0];
              end else begin
                ptr <= ptr + 8'd1;
              end
            end
          end
          3'd7: begin
            if (state == IDLE) begin
              cmd       <= wr_hold[7:0];
              bsy       <= 1'b1;
              err       <= 1'b0;
              ide_intrq <= 1'b0;
              cnt       <= '0;
              state     <= CMDWAIT;
            end
          end
          default: begin
            if (!bsy) begin
              case (ide_da)
                3'd2:    seccnt  <= wr_hold[7:0];
                3'd3:    secnum  <= wr_hold[7:0];
                3'd4:    cyllow  <= wr_hold[7:0];
                3'd5:    cylhigh <= wr_hold[7:0];
                3'd6:    drvhead <= wr_hold[7:0];
                default: ;
              endcase
            end
          end
        endcase
      end

      // soft reset overrides anything decided above this clock
      if (wr_commit && sel_ctl && ide_da == 3'd6) begin
        devctrl <= wr_hold[7:0];
        if (wr_hold[2] && !devctrl[2]) begin
          state     <= RESETTING;
          bsy       <= 1'b1;
          drq       <= 1'b0;
          ide_intrq <= 1'b0;
          blk_rd    <= 1'b0;
          blk_wr    <= 1'b0;
          fill_vld  <= 1'b0;
          cnt       <= '0;
          ptr       <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ide_device.sv
`timescale 1ns/1ps
// Scoreboard bench for ide_device: host PIO tasks push expectations, monitors pop and compare.
module tb_ide_device;
  localparam logic [23:0] SECTORS = 24'd65536;

  logic        clk = 1'b0;
  logic        reset;
  wire  [15:0] ide_data_bus;
  logic        ide_dior, ide_diow;
  logic [1:0]  ide_cs;
  logic [2:0]  ide_da;
  logic        ide_intrq;
  logic [23:0] blk_lba;
  logic [7:0]  blk_addr;
  logic        blk_rd, blk_wr;
  logic [15:0] blk_wdata, blk_rdata;
  logic        tb_oe;
  logic [15:0] tb_data;

  always #5 clk = ~clk;
  assign ide_data_bus = tb_oe ? tb_data : 16'hzzzz;

  ide_device #(.SECTORS(SECTORS), .BSY_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .ide_data_bus(ide_data_bus),
    .ide_dior(ide_dior), .ide_diow(ide_diow), .ide_cs(ide_cs), .ide_da(ide_da),
    .ide_intrq(ide_intrq), .blk_lba(blk_lba), .blk_addr(blk_addr),
    .blk_rd(blk_rd), .blk_wr(blk_wr), .blk_wdata(blk_wdata), .blk_rdata(blk_rdata)
  );

  logic [15:0] store5 [256];
  always @(posedge clk) if (blk_rd) blk_rdata <= (blk_lba == 24'd5) ? store5[blk_addr] : 16'hDEAD;

  int n_chk = 0, n_fail = 0, rd_strobes = 0, wr_strobes = 0;
  logic [15:0] exp_q[$];
  string       nm_q[$];
  logic [47:0] wexp_q[$];
  event        rd_ev;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // bus-read monitor
  initial begin
    logic [15:0] e;
    string n;
    forever begin
      @(rd_ev);
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_unexpected: got %h with empty scoreboard", ide_data_bus);
      end else begin
        e = exp_q.pop_front();
        n = nm_q.pop_front();
        if (ide_data_bus !== e) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h", n, ide_data_bus, e);
        end
      end
    end
  end

  // store-port monitor
  always @(negedge clk) begin
    if (reset === 1'b1 && blk_rd) rd_strobes++;
    if (reset === 1'b1 && blk_wr) begin
      wr_strobes++;
      n_chk++;
      if (wexp_q.size() == 0) begin
        n_fail++;
        $display("FAIL blk_wr_unexpected: got lba %h addr %h data %h", blk_lba, blk_addr, blk_wdata);
      end else if ({blk_lba, blk_addr, blk_wdata} !== wexp_q[0]) begin
        n_fail++;
        $display("FAIL blk_wr: got %h expected %h", {blk_lba, blk_addr, blk_wdata}, wexp_q[0]);
        void'(wexp_q.pop_front());
      end else begin
        void'(wexp_q.pop_front());
      end
    end
  end

  task automatic host_wr(input logic [1:0] cs, input logic [2:0] da, input logic [15:0] d);
    @(negedge clk);
    ide_cs = cs; ide_da = da; tb_data = d; tb_oe = 1'b1; ide_diow = 1'b0;
    repeat (4) @(negedge clk);
    ide_diow = 1'b1;
    repeat (4) @(negedge clk);
    tb_oe = 1'b0; ide_cs = 2'b11;
  endtask

  task automatic host_rd(input logic [1:0] cs, input logic [2:0] da, input logic [15:0] exp, input string nm);
    @(negedge clk);
    ide_cs = cs; ide_da = da; ide_dior = 1'b0;
    repeat (3) @(negedge clk);
    exp_q.push_back(exp);
    nm_q.push_back(nm);
    -> rd_ev;
    @(negedge clk);
    ide_dior = 1'b1;
    repeat (4) @(negedge clk);
    ide_cs = 2'b11;
  endtask

  task automatic set_lba(input logic [23:0] l);
    host_wr(2'b10, 3'd3, {8'h00, l[7:0]});
    host_wr(2'b10, 3'd4, {8'h00, l[15:8]});
    host_wr(2'b10, 3'd5, {8'h00, l[23:16]});
  endtask

  initial begin
    int rd_before;
    logic [15:0] w;
    reset = 1'b0; ide_dior = 1'b1; ide_diow = 1'b1; ide_cs = 2'b11; ide_da = '0;
    tb_oe = 1'b0; tb_data = '0;
    for (int i = 0; i < 256; i++) store5[i] = 16'h0100 + 16'(i);
    repeat (3) @(negedge clk);
    chk("rst_intrq", ide_intrq, 0);
    chk("rst_blk_strobes", {blk_rd, blk_wr}, 0);
    chk("rst_blk_addr_lba", {blk_lba, blk_addr}, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // dior high: device must leave the bus to the host
    ide_cs = 2'b10; ide_da = 3'd7; tb_data = 16'h0000; tb_oe = 1'b1;
    @(negedge clk);
    chk("bus_hiz", ide_data_bus, 16'h0000);
    tb_oe = 1'b0; ide_cs = 2'b11;
    host_rd(2'b10, 3'd7, 16'h0050, "rst_status");
    host_rd(2'b10, 3'd1, 16'h0001, "rst_error");

    // READ SECTOR at LBA 5
    set_lba(24'd5);
    host_wr(2'b10, 3'd2, 16'h0001);
    host_wr(2'b10, 3'd6, 16'h0040);
    host_wr(2'b10, 3'd7, 16'h0020);
    host_rd(2'b10, 3'd7, 16'h00D0, "rd_busy");
    host_rd(2'b01, 3'd6, 16'h00D0, "rd_alt_busy");
    repeat (300) @(negedge clk);
    chk("rd_intrq_set", ide_intrq, 1);
    host_rd(2'b01, 3'd6, 16'h0058, "rd_altstatus");
    chk("alt_keeps_intrq", ide_intrq, 1);
    host_rd(2'b10, 3'd7, 16'h0058, "rd_drq");
    chk("rd_intrq_clr", ide_intrq, 0);
    for (int i = 0; i < 256; i++) host_rd(2'b10, 3'd0, 16'h0100 + 16'(i), "rd_data");
    host_rd(2'b10, 3'd7, 16'h0050, "rd_done");
    chk("rd_strobes", rd_strobes, 256);

    // WRITE SECTOR at LBA 7 with nIEN
    host_wr(2'b01, 3'd6, 16'h0002);
    set_lba(24'd7);
    host_wr(2'b10, 3'd7, 16'h0030);
    repeat (20) @(negedge clk);
    host_rd(2'b10, 3'd7, 16'h0058, "wr_drq");
    chk("wr_intrq_drq", ide_intrq, 0);
    for (int i = 0; i < 256; i++) begin
      wexp_q.push_back({24'd7, 8'(i), 16'hA000 + 16'(i)});
      host_wr(2'b10, 3'd0, 16'hA000 + 16'(i));
    end
    repeat (300) @(negedge clk);
    chk("wr_strobes", wr_strobes, 256);
    chk("wr_q_drained", wexp_q.size(), 0);
    chk("wr_intrq_done", ide_intrq, 0);
    host_rd(2'b10, 3'd7, 16'h0050, "wr_done");

    // out-of-range LBA aborts
    host_wr(2'b01, 3'd6, 16'h0000);
    set_lba(SECTORS);
    rd_before = rd_strobes;
    host_wr(2'b10, 3'd7, 16'h0020);
    repeat (30) @(negedge clk);
    chk("abort_intrq", ide_intrq, 1);
    host_rd(2'b10, 3'd7, 16'h0051, "abort_status");
    host_rd(2'b10, 3'd1, 16'h0004, "abort_error");
    chk("abort_no_rd", rd_strobes, rd_before);

    // soft reset in the middle of a read transfer
    set_lba(24'd5);
    host_wr(2'b10, 3'd7, 16'h0020);
    repeat (300) @(negedge clk);
    host_rd(2'b10, 3'd7, 16'h0058, "srst_pre_drq");
    for (int i = 0; i < 100; i++) host_rd(2'b10, 3'd0, 16'h0100 + 16'(i), "srst_pre_data");
    host_wr(2'b01, 3'd6, 16'h0004);
    host_rd(2'b10, 3'd7, 16'h00D0, "srst_busy");
    host_wr(2'b01, 3'd6, 16'h0000);
    repeat (20) @(negedge clk);
    host_rd(2'b10, 3'd7, 16'h0050, "srst_idle");
    host_rd(2'b10, 3'd0, 16'h0000, "srst_data_zero");

    // IDENTIFY DEVICE
    host_wr(2'b10, 3'd7, 16'h00EC);
    repeat (300) @(negedge clk);
`ifdef IDE_DEVICE_IDENTIFY_EN
    host_rd(2'b10, 3'd7, 16'h0058, "id_drq");
    for (int i = 0; i < 256; i++) begin
      w = 16'h0000;
      if (i == 49) w = 16'h0200;
      if (i == 60) w = SECTORS[15:0];
      if (i == 61) w = {8'h00, SECTORS[23:16]};
      host_rd(2'b10, 3'd0, w, "id_word");
    end
    host_rd(2'b10, 3'd7, 16'h0050, "id_done");
`else
    w = 16'h0004;
    host_rd(2'b10, 3'd7, 16'h0051, "id_abort_status");
    host_rd(2'b10, 3'd1, w, "id_abort_error");
`endif

    repeat (4) @(negedge clk);
    chk("rd_q_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
